// File: rtl/simple_serializer.sv
// ---------------------------------------------------------------------------
// simple_serializer
//
// Width-down converter between two access-enable stages. It pops one
// WIDTH-bit word from the upstream single-entry buffer and pushes it
// downstream as RATIO = WIDTH/SLICE_WIDTH consecutive SLICE_WIDTH-bit slices.
// Neither neighbour protects itself, so this block never pops an empty
// upstream stage and never pushes into a full downstream stage.
//
// Optional feature: define SIMPLE_SERIALIZER_MSB_FIRST_EN to emit the
// most-significant slice first. The default build emits the least-significant
// slice first. Handshake, timing and reset behaviour are the same either way.
//
// Ports:
//   clock                    rising-edge clock
//   resetn                   asynchronous, active-low reset
//   upstream_empty           upstream stage holds no word
//   upstream_read_enable     pop request; consumes upstream_read_data this cycle
//   upstream_read_data       upstream word, valid while upstream_empty is low
//   downstream_full          downstream stage cannot accept a slice
//   downstream_write_enable  push request to the downstream stage
//   downstream_write_data    slice currently presented downstream
//   busy                     a word is held and not yet fully emitted
// ---------------------------------------------------------------------------
module simple_serializer #(
  parameter int WIDTH       = 32,
  parameter int SLICE_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   upstream_empty,
  output logic                   upstream_read_enable,
  input  logic [WIDTH-1:0]       upstream_read_data,
  input  logic                   downstream_full,
  output logic                   downstream_write_enable,
  output logic [SLICE_WIDTH-1:0] downstream_write_data,
  output logic                   busy
);

  localparam int RATIO       = WIDTH / SLICE_WIDTH;
  localparam int INDEX_WIDTH = $clog2(RATIO);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(RATIO - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                   state;
  logic [WIDTH-1:0]         holding;
  logic [INDEX_WIDTH-1:0]   index;
  logic [SLICE_WIDTH-1:0]   slices [RATIO];
  logic                     last_slice;

  // Slice k of the held word in emission order. Only the ordering differs
  // between builds; the index counter always runs 0..RATIO-1.
  for (genvar k = 0; k < RATIO; k++) begin : g_slice
`ifdef SIMPLE_SERIALIZER_MSB_FIRST_EN
    assign slices[k] = holding[(RATIO-1-k)*SLICE_WIDTH +: SLICE_WIDTH];
`else
    assign slices[k] = holding[k*SLICE_WIDTH +: SLICE_WIDTH];
`endif
  end

  assign last_slice = (index == LAST_INDEX);

  // Data comes only from registered state, so there is no path from
  // upstream_read_data to the downstream outputs. Outside SEND the bus is
  // forced to zero so that a word left over in the holding register is
  // never visible.
  assign downstream_write_data = (state == SEND) ? slices[index] : '0;

  assign downstream_write_enable = (state == SEND) && !downstream_full;

  // In SEND a new word may only be popped on the cycle the final slice is
  // actually written, which lets the next word follow without a bubble.
  assign upstream_read_enable = (state == IDLE)
                                ? !upstream_empty
                                : (!downstream_full && last_slice && !upstream_empty);

  assign busy = (state == SEND);

  // Main FSM. A stalled downstream leaves holding and index untouched so the
  // presented slice stays stable until it is accepted. Reset discards any
  // partially emitted word.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      holding <= '0;
      index   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (upstream_read_enable) begin
            holding <= upstream_read_data;
            index   <= '0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (downstream_write_enable) begin
            if (!last_slice) begin
              index <= index + 1'b1;
            end else begin
              index <= '0;
              if (!upstream_empty) begin
                holding <= upstream_read_data;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          index <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_serializer.sv
// ---------------------------------------------------------------------------
// tb_simple_serializer
//
// Scoreboard bench for simple_serializer. An upstream model supplies words
// from a source queue; each time the DUT pops a word, the slices it must
// produce are computed arithmetically and queued. A downstream monitor pops
// one expected slice per observed write and compares. Directed sequences
// check handshake timing, stalls and reset; a randomized phase with random
// upstream gaps and downstream back-pressure follows.
// ---------------------------------------------------------------------------
module tb_simple_serializer;

  localparam int WIDTH       = 32;
  localparam int SLICE_WIDTH = 8;
  localparam int RATIO       = WIDTH / SLICE_WIDTH;

  logic                   clock;
  logic                   resetn;
  logic                   upstream_empty;
  logic                   upstream_read_enable;
  logic [WIDTH-1:0]       upstream_read_data;
  logic                   downstream_full;
  logic                   downstream_write_enable;
  logic [SLICE_WIDTH-1:0] downstream_write_data;
  logic                   busy;

  simple_serializer #(
    .WIDTH       (WIDTH),
    .SLICE_WIDTH (SLICE_WIDTH)
  ) dut (
    .clock                   (clock),
    .resetn                  (resetn),
    .upstream_empty          (upstream_empty),
    .upstream_read_enable    (upstream_read_enable),
    .upstream_read_data      (upstream_read_data),
    .downstream_full         (downstream_full),
    .downstream_write_enable (downstream_write_enable),
    .downstream_write_data   (downstream_write_data),
    .busy                    (busy)
  );

  logic [WIDTH-1:0]       src_q [$];
  logic [SLICE_WIDTH-1:0] exp_q [$];
  int checks       = 0;
  int failures     = 0;
  int gap_pct      = 0;
  int full_pct     = 0;
  int words_pushed = 0;
  int words_read   = 0;
  logic full_force = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference ordering of slices: slice k of a word in emission order.
  function automatic logic [SLICE_WIDTH-1:0] slice_of(input logic [WIDTH-1:0] w, input int k);
`ifdef SIMPLE_SERIALIZER_MSB_FIRST_EN
    return SLICE_WIDTH'(w >> ((RATIO - 1 - k) * SLICE_WIDTH));
`else
    return SLICE_WIDTH'(w >> (k * SLICE_WIDTH));
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives the upstream and downstream inputs shortly after every rising
  // edge, from the source queue and the configured gap/stall rates.
  task automatic applyStimulus();
    if (src_q.size() == 0 || (gap_pct != 0 && $urandom_range(99) < gap_pct)) begin
      upstream_empty     = 1'b1;
      upstream_read_data = $urandom;
    end else begin
      upstream_empty     = 1'b0;
      upstream_read_data = src_q[0];
    end
    downstream_full = full_force || (full_pct != 0 && $urandom_range(99) < full_pct);
  endtask

  always @(posedge clock) begin
    #1;
    applyStimulus();
  end

  // Upstream model: on every pop, the word leaves the source queue and its
  // slices become the expected downstream traffic.
  always @(negedge clock) begin
    if (resetn && upstream_read_enable) begin
      checkOutput("read_while_empty", 32'(upstream_empty), 32'd0);
      for (int k = 0; k < RATIO; k++) exp_q.push_back(slice_of(upstream_read_data, k));
      if (src_q.size() != 0) void'(src_q.pop_front());
      words_read++;
    end
  end

  // Downstream monitor: every accepted write consumes one expected slice.
  always @(negedge clock) begin
    if (resetn && downstream_write_enable) begin
      checkOutput("write_while_full", 32'(downstream_full), 32'd0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 32'd1, 32'd0);
      end else begin
        checkOutput("slice_data", 32'(downstream_write_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_read_en"},  32'(upstream_read_enable),    32'd0);
    checkOutput({name, "_write_en"}, 32'(downstream_write_enable), 32'd0);
    checkOutput({name, "_data"},     32'(downstream_write_data),   32'd0);
    checkOutput({name, "_busy"},     32'(busy),                    32'd0);
  endtask

  task automatic waitRead(output bit found);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (upstream_read_enable) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("wait_read", 32'(found), 32'd1);
  endtask

  task automatic pushWord(input logic [WIDTH-1:0] w);
    src_q.push_back(w);
    words_pushed++;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit found;
    bit drained;
    resetn             = 1'b0;
    upstream_empty     = 1'b1;
    upstream_read_data = '0;
    downstream_full    = 1'b0;

    repeat (3) @(posedge clock);
    #2;
    checkIdleOutputs("reset");
    @(negedge clock);
    resetn = 1'b1;

    // Upstream empty after reset: nothing moves.
    repeat (10) begin
      @(negedge clock);
      checkOutput("empty_read_en",  32'(upstream_read_enable),    32'd0);
      checkOutput("empty_write_en", 32'(downstream_write_enable), 32'd0);
      checkOutput("empty_busy",     32'(busy),                    32'd0);
    end

    // Single word: one pop, then RATIO consecutive writes.
    pushWord(32'hDDCCBBAA);
    waitRead(found);
    for (int i = 0; i < RATIO; i++) begin
      @(negedge clock);
      checkOutput("single_write_en", 32'(downstream_write_enable), 32'd1);
      checkOutput("single_read_en",  32'(upstream_read_enable),    32'd0);
      checkOutput("single_busy",     32'(busy),                    32'd1);
    end
    @(negedge clock);
    checkOutput("single_busy_fall", 32'(busy),                    32'd0);
    checkOutput("single_write_end", 32'(downstream_write_enable), 32'd0);

    // Back-to-back words: second pop coincides with the last slice write.
    pushWord(32'h44332211);
    pushWord(32'h88776655);
    waitRead(found);
    for (int i = 1; i <= 2 * RATIO; i++) begin
      @(negedge clock);
      checkOutput("b2b_write_en", 32'(downstream_write_enable), 32'd1);
      checkOutput("b2b_read_en",  32'(upstream_read_enable),    (i == RATIO) ? 32'd1 : 32'd0);
    end
    @(negedge clock);
    checkOutput("b2b_busy_fall", 32'(busy), 32'd0);

    // Downstream stall on the second slice for three cycles.
    pushWord(32'hDDCCBBAA);
    waitRead(found);
    @(negedge clock);
    checkOutput("stall_first_write", 32'(downstream_write_enable), 32'd1);
    full_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("stall_write_en", 32'(downstream_write_enable), 32'd0);
      checkOutput("stall_data",     32'(downstream_write_data),   32'(slice_of(32'hDDCCBBAA, 1)));
    end
    full_force = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("stall_resume", 32'(downstream_write_enable), 32'd1);
    end
    @(negedge clock);
    checkOutput("stall_busy_fall", 32'(busy), 32'd0);

    // Reset after the second slice is written: the rest is discarded.
    pushWord(32'hDDCCBBAA);
    waitRead(found);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    checkIdleOutputs("midreset");
    @(negedge clock);
    resetn = 1'b1;
    repeat (8) begin
      @(negedge clock);
      checkOutput("postreset_write_en", 32'(downstream_write_enable), 32'd0);
      checkOutput("postreset_busy",     32'(busy),                    32'd0);
    end

    // Randomized traffic with upstream gaps and downstream back-pressure.
    gap_pct  = 25;
    full_pct = 30;
    for (int i = 0; i < 300; i++) pushWord($urandom);
    drained = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clock);
      if (src_q.size() == 0 && exp_q.size() == 0 && !busy) begin
        drained = 1'b1;
        break;
      end
    end
    checkOutput("random_drained", 32'(drained), 32'd1);
    checkOutput("words_read", 32'(words_read), 32'(words_pushed));
    checkOutput("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
